// File: rtl/beidou_pkg.sv
// -----------------------------------------------------------------------------
// beidou_pkg
// Shared types and constants for the BeiDou D1 frame controller.
//   state_t          : frame-sync FSM states (HUNT / TRACK)
//   PREAMBLE         : 11-bit subframe preamble, MSB received first
//   WORD_BITS_DEF    : default bits per navigation word
//   WORDS_PER_SF_DEF : default words per subframe
//   ENERGY_W_DEF     : default signed energy / threshold width
// -----------------------------------------------------------------------------
package beidou_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam int                PRE_LEN          = 11;
    localparam logic [PRE_LEN-1:0] PREAMBLE        = 11'b11100010010;
    localparam int                WORD_BITS_DEF    = 30;
    localparam int                WORDS_PER_SF_DEF = 10;
    localparam int                ENERGY_W_DEF     = 50;

endpackage

// File: rtl/beidou_bit_slicer.sv
// -----------------------------------------------------------------------------
// beidou_bit_slicer
// Registered hard-decision slicer: bit_dec = (energy >= cfg_thresh), signed,
// full width. One-cycle latency from energy_vld to bit_vld.
//   clk, rst     : clock, asynchronous active-high reset
//   energy       : signed bit energy
//   cfg_thresh   : signed slicing threshold
//   energy_vld   : sample strobe (already qualified by decode enable)
//   bit_dec      : sliced bit
//   bit_vld      : bit_dec valid strobe
// -----------------------------------------------------------------------------
module beidou_bit_slicer
    import beidou_pkg::*;
#(
    parameter int ENERGY_W = ENERGY_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [ENERGY_W-1:0] energy,
    input  logic signed [ENERGY_W-1:0] cfg_thresh,
    input  logic                       energy_vld,
    output logic                       bit_dec,
    output logic                       bit_vld
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_dec <= 1'b0;
            bit_vld <= 1'b0;
        end else begin
            bit_vld <= energy_vld;
            if (energy_vld) begin
                bit_dec <= (energy >= cfg_thresh);
            end
        end
    end

endmodule

// File: rtl/beidou_frame_ctrl.sv
// -----------------------------------------------------------------------------
// beidou_frame_ctrl
// Slices energy samples into bits, hunts for the subframe preamble, packs the
// bit stream into navigation words and hands them out through a single-entry
// valid/ready buffer.
//   clk, rst    : clock, asynchronous active-high reset
//   enable      : decode enable; low forces HUNT and ignores samples
//   cfg_thresh  : signed slicing threshold
//   energy      : signed bit energy, qualified by energy_vld
//   word        : completed word, MSB = first received bit
//   word_idx    : word number within the subframe
//   word_vld    : word / word_idx valid
//   word_rdy    : consumer ready
//   locked      : high while frame-synchronised
//   word_drop   : one-cycle pulse when a completed word finds the buffer full
// -----------------------------------------------------------------------------
module beidou_frame_ctrl
    import beidou_pkg::*;
#(
    parameter int ENERGY_W     = ENERGY_W_DEF,
    parameter int WORD_BITS    = WORD_BITS_DEF,
    parameter int WORDS_PER_SF = WORDS_PER_SF_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic signed [ENERGY_W-1:0] cfg_thresh,
    input  logic signed [ENERGY_W-1:0] energy,
    input  logic                       energy_vld,
    output logic [WORD_BITS-1:0]       word,
    output logic [3:0]                 word_idx,
    output logic                       word_vld,
    input  logic                       word_rdy,
    output logic                       locked,
    output logic                       word_drop
);

    localparam int BCNT_W = $clog2(WORD_BITS);

    logic                 bit_dec;
    logic                 bit_vld;
    state_t               state, state_n;
    logic [WORD_BITS-1:0] sr, sr_n, sr_shift;
    logic [BCNT_W-1:0]    bcnt, bcnt_n;
    logic [3:0]           widx, widx_n;
    logic                 word_done;
    logic                 buf_free;

    beidou_bit_slicer #(
        .ENERGY_W (ENERGY_W)
    ) u_slicer (
        .clk        (clk),
        .rst        (rst),
        .energy     (energy),
        .cfg_thresh (cfg_thresh),
        .energy_vld (energy_vld && enable),
        .bit_dec    (bit_dec),
        .bit_vld    (bit_vld)
    );

    assign sr_shift = {sr[WORD_BITS-2:0], bit_dec};
    assign locked   = (state == TRACK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
            sr    <= '0;
            bcnt  <= '0;
            widx  <= '0;
        end else begin
            state <= state_n;
            sr    <= sr_n;
            bcnt  <= bcnt_n;
            widx  <= widx_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        sr_n      = sr;
        bcnt_n    = bcnt;
        widx_n    = widx;
        word_done = 1'b0;

        if (!enable) begin
            state_n = HUNT;
            sr_n    = '0;
            bcnt_n  = '0;
            widx_n  = '0;
        end else if (bit_vld) begin
            sr_n = sr_shift;
            unique case (state)
                HUNT: begin
                    // Lock lands mid-word: the preamble already fills the
                    // first PRE_LEN bits of word 0.
                    if (sr_shift[PRE_LEN-1:0] == PREAMBLE) begin
                        state_n = TRACK;
                        bcnt_n  = BCNT_W'(PRE_LEN);
                        widx_n  = '0;
                    end
                end
                TRACK: begin
                    if (bcnt == BCNT_W'(WORD_BITS - 1)) begin
                        word_done = 1'b1;
                        bcnt_n    = '0;
                        widx_n    = (widx == 4'(WORDS_PER_SF - 1)) ? 4'd0 : widx + 4'd1;
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                        // Start of every later subframe must repeat the preamble.
                        if (widx == 4'd0 && bcnt == BCNT_W'(PRE_LEN - 1) &&
                            sr_shift[PRE_LEN-1:0] != PREAMBLE) begin
                            state_n = HUNT;
                            bcnt_n  = '0;
                            widx_n  = '0;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    // Buffer can take a new word when empty or when draining this cycle.
    assign buf_free = !word_vld || word_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word      <= '0;
            word_idx  <= '0;
            word_vld  <= 1'b0;
            word_drop <= 1'b0;
        end else begin
            word_drop <= 1'b0;
            if (word_done && buf_free) begin
                word     <= sr_shift;
                word_idx <= widx;
                word_vld <= 1'b1;
            end else begin
                if (word_vld && word_rdy) begin
                    word_vld <= 1'b0;
                end
                if (word_done) begin
                    word_drop <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_beidou_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_beidou_frame_ctrl
// Self-checking bench: a bit-level reference model predicts every completed
// word (value, index, due cycle) into a queue; a monitor matches buffer
// loads, drops and handshakes against that queue.
// -----------------------------------------------------------------------------
module tb_beidou_frame_ctrl;

    localparam int          EW    = 50;
    localparam int          WB    = 30;
    localparam int          NW    = 10;
    localparam int          SF    = WB * NW;
    localparam logic [10:0] PRE   = 11'b11100010010;

    typedef struct {
        logic [WB-1:0] w;
        logic [3:0]    idx;
        int            due;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 enable = 1'b0;
    logic signed [EW-1:0] cfg_thresh = '0;
    logic signed [EW-1:0] energy = '0;
    logic                 energy_vld = 1'b0;
    logic [WB-1:0]        word;
    logic [3:0]           word_idx;
    logic                 word_vld;
    logic                 word_rdy = 1'b0;
    logic                 locked;
    logic                 word_drop;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   drop_cnt = 0;
    bit   rdy_rand = 1'b0;

    exp_t exp_q[$];
    bit   hist[$];
    bit   m_locked = 1'b0;
    int   m_pos = 0;

    beidou_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cfg_thresh (cfg_thresh),
        .energy     (energy),
        .energy_vld (energy_vld),
        .word       (word),
        .word_idx   (word_idx),
        .word_vld   (word_vld),
        .word_rdy   (word_rdy),
        .locked     (locked),
        .word_drop  (word_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [WB-1:0] tail_bits(input int n);
        logic [WB-1:0] v = '0;
        int s = hist.size();
        for (int i = 0; i < n; i++) begin
            int k = s - n + i;
            v = {v[WB-2:0], (k >= 0) ? hist[k] : 1'b0};
        end
        return v;
    endfunction

    function automatic void model_reset();
        hist.delete();
        m_locked = 1'b0;
        m_pos    = 0;
    endfunction

    // m_pos counts bits since the start of the current subframe.
    function automatic void model_step(input bit b, input int due);
        exp_t e;
        hist.push_back(b);
        if (hist.size() > WB) void'(hist.pop_front());
        if (!m_locked) begin
            if (tail_bits(11) == WB'(PRE)) begin
                m_locked = 1'b1;
                m_pos    = 11;
            end
        end else begin
            m_pos++;
            if (m_pos % WB == 0) begin
                e.w   = tail_bits(WB);
                e.idx = 4'(m_pos / WB - 1);
                e.due = due;
                exp_q.push_back(e);
            end
            if (m_pos == SF) m_pos = 0;
            if (m_pos == 11 && tail_bits(11) != WB'(PRE)) begin
                m_locked = 1'b0;
                m_pos    = 0;
            end
        end
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive(input longint e, input longint th);
        @(posedge clk); #1;
        energy     = EW'(e);
        cfg_thresh = EW'(th);
        energy_vld = 1'b1;
        model_step(e >= th, cyc + 2);
    endtask

    task automatic send_bit(input bit b);
        longint th = (longint'($urandom) - 64'sd2147483648) * 256;
        longint e  = b ? th + longint'($urandom_range(0, 1000000))
                       : th - 1 - longint'($urandom_range(0, 1000000));
        drive(e, th);
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom));
    endtask

    task automatic send_pat(input logic [10:0] p);
        for (int i = 10; i >= 0; i--) send_bit(p[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            energy_vld = 1'b0;
        end
    endtask

    task automatic set_enable(input bit en);
        @(posedge clk); #1;
        energy_vld = 1'b0;
        enable     = en;
        if (!en) model_reset();
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) word_rdy = 1'($urandom);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic          last_vld = 1'b0;
    logic          last_acc = 1'b0;
    logic [WB-1:0] hold_w = '0;
    logic [3:0]    hold_i = '0;

    always @(negedge clk) begin
        if (rst) begin
            last_vld = 1'b0;
            last_acc = 1'b0;
        end else begin
            if (word_vld && last_vld && !last_acc) begin
                check("held_word", word, hold_w);
                check("held_idx", 64'(word_idx), 64'(hold_i));
            end
            if (word_vld && (!last_vld || last_acc)) begin
                check("word_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    check("word_value", word, exp_q[0].w);
                    check("word_idx", 64'(word_idx), 64'(exp_q[0].idx));
                    check("word_latency", 64'(cyc), 64'(exp_q[0].due));
                end
            end
            if (word_drop) begin
                drop_cnt++;
                check("drop_expected", 64'(exp_q.size() >= 2), 64'd1);
                if (exp_q.size() >= 2) begin
                    check("drop_latency", 64'(cyc), 64'(exp_q[1].due));
                    exp_q.delete(1);
                end
            end
            if (word_vld && word_rdy && exp_q.size() > 0) void'(exp_q.pop_front());
            last_vld = word_vld;
            last_acc = word_vld && word_rdy;
            hold_w   = word;
            hold_i   = word_idx;
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int d0;
        logic [10:0] bad;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_word", word, 0);
        check("rst_word_idx", 64'(word_idx), 0);
        check("rst_word_vld", 64'(word_vld), 0);
        check("rst_locked", 64'(locked), 0);
        check("rst_word_drop", 64'(word_drop), 0);
        idle(100);
        check("idle_locked", 64'(locked), 0);
        check("idle_word_vld", 64'(word_vld), 0);

        // Acquisition, slicer boundary inside the first payload bits.
        set_enable(1'b1);
        word_rdy = 1'b1;
        send_rand(20);
        send_pat(PRE);
        idle(3);
        check("acq_locked", 64'(locked), 64'(m_locked));
        drive(64'sd14999999999, 64'sd15000000000);
        drive(64'sd15000000000, 64'sd15000000000);
        drive(-64'sd1,          64'sd15000000000);
        send_rand(16);
        send_rand(9 * WB);
        check("sf1_locked", 64'(locked), 64'(m_locked));

        // Second subframe back-to-back, then a corrupted preamble.
        send_pat(PRE);
        send_rand(SF - 11);
        idle(3);
        check("sf2_locked", 64'(locked), 64'(m_locked));
        bad = PRE ^ (11'd1 << $urandom_range(0, 10));
        send_pat(bad);
        idle(3);
        check("recheck_locked", 64'(locked), 64'(m_locked));
        send_rand(19);
        idle(5);
        check("recheck_no_word", 64'(exp_q.size()), 0);

        // Backpressure across two completions.
        set_enable(1'b0);
        set_enable(1'b1);
        word_rdy = 1'b0;
        d0 = drop_cnt;
        send_pat(PRE);
        send_rand(19 + WB);
        idle(5);
        check("bp_drop_count", 64'(drop_cnt - d0), 1);
        check("bp_word_vld", 64'(word_vld), 1);
        word_rdy = 1'b1;
        send_rand(WB);
        idle(4);

        // Enable drop mid-word with a word buffered.
        word_rdy = 1'b0;
        send_rand(WB);
        send_rand(15);
        idle(2);
        set_enable(1'b0);
        idle(3);
        check("en_locked", 64'(locked), 0);
        check("en_word_kept", 64'(word_vld), 1);
        word_rdy = 1'b1;
        idle(3);
        check("en_delivered", 64'(exp_q.size()), 0);
        set_enable(1'b1);
        for (int i = 0; i < WB; i++) send_bit(1'b0);
        idle(3);
        check("reacq_wait", 64'(locked), 64'(m_locked));
        send_pat(PRE);
        idle(3);
        check("reacq_locked", 64'(locked), 64'(m_locked));

        // Randomised traffic with random backpressure and gaps.
        rdy_rand = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 49) == 0) send_pat(PRE);
            else send_bit(1'($urandom));
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        idle(4);
        rdy_rand = 1'b0;
        word_rdy = 1'b1;
        idle(10);
        check("rand_drained", 64'(exp_q.size()), 0);
        check("rand_locked", 64'(locked), 64'(m_locked));

        // Reset mid-handshake.
        set_enable(1'b0);
        set_enable(1'b1);
        word_rdy = 1'b0;
        send_pat(PRE);
        send_rand(19);
        for (int i = 0; i < 20 && !word_vld; i++) idle(1);
        check("wait_word_vld", 64'(word_vld), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_word_vld", 64'(word_vld), 0);
        check("rst_mid_locked", 64'(locked), 0);
        exp_q.delete();
        model_reset();
        energy_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(5);
        check("post_rst_word_vld", 64'(word_vld), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
